// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the decode-stage hazard scoreboard.
// Types only, plus the bypass-select priority helper (combinational, no state).
package hazard_pkg;

  localparam int NREG_DEF = 32;
  localparam int LW_DEF   = 4;
  localparam int SLOT_AW  = 8;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_LONG = 2'b10,
    CLS_RSVD = 2'b11
  } cls_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_t;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
  } slot_t;

  // Youngest producer wins; x0 is never bypassed.
  function automatic fwd_t fwd_pick(input logic [SLOT_AW-1:0] rs,
                                    input slot_t ex, input slot_t mem, input slot_t wb);
    fwd_t sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (ex.valid && ex.rd == rs)        sel = FWD_EX;
      else if (mem.valid && mem.rd == rs) sel = FWD_MEM;
      else if (wb.valid && wb.rd == rs)   sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: instruction fields in, bypass selects and pipeline control out.
// master = decode stage, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int LW = 4
);
  logic          dec_valid;
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;
  logic          dec_rs1_use;
  logic          dec_rs2_use;
  logic [AW-1:0] dec_rd;
  logic          dec_we;
  logic [1:0]    dec_cls;
  logic [LW-1:0] dec_long_lat;
  logic          pc_change_ex;
  logic [1:0]    fwd_sel_rs1;
  logic [1:0]    fwd_sel_rs2;
  logic          stall_if;
  logic          stall_dec;
  logic          flush_dec;
  logic          flush_ex;
  logic [31:0]   stall_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_use, dec_rs2_use, dec_rd, dec_we,
           dec_cls, dec_long_lat, pc_change_ex,
    input  fwd_sel_rs1, fwd_sel_rs2, stall_if, stall_dec, flush_dec, flush_ex, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_use, dec_rs2_use, dec_rd, dec_we,
           dec_cls, dec_long_lat, pc_change_ex,
    output fwd_sel_rs1, fwd_sel_rs2, stall_if, stall_dec, flush_dec, flush_ex, stall_cnt
  );
endinterface

// File: rtl/hazard_pend_entry.sv
// One register's pending-result countdown: loads on issue, otherwise counts down to zero.
// Value visible the cycle after load; no backpressure.
module hazard_pend_entry #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [LW-1:0] load_val,
  output logic [LW-1:0] pend
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pend <= '0;
    else if (load)          pend <= load_val;
    else if (pend != '0)    pend <= pend - LW'(1);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: RAW/WAW/structural stall detection, bypass selects, flush control.
// Stall/flush/fwd are combinational in the decode cycle; a stall holds decode and bubbles EX.
import hazard_pkg::*;

module hazard_scoreboard #(
  parameter int NREG     = NREG_DEF,
  parameter int AW       = $clog2(NREG),
  parameter int LW       = LW_DEF,
  parameter int LOAD_LAT = 1
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);

  cls_t          cls;
  logic          is_long;
  logic          is_load;
  logic [LW-1:0] long_lat_eff;
  logic [LW-1:0] load_val;
  logic [LW-1:0] pend [NREG];
  logic [LW-1:0] long_cnt;
  logic          raw, waw, struct_haz, hazard, stall, issue, tracked;
  slot_t         ex_s, mem_s, wb_s;
  logic [31:0]   stall_cnt_q;

  assign cls          = cls_t'(sb.dec_cls);
  assign is_long      = (cls == CLS_LONG);
  assign is_load      = (cls == CLS_LOAD);
  assign long_lat_eff = (sb.dec_long_lat == '0) ? LW'(1) : sb.dec_long_lat;

  // Reserved class falls through to the ALU case (result ready next cycle).
  always_comb begin
    load_val = '0;
    if (is_load)      load_val = LW'(LOAD_LAT);
    else if (is_long) load_val = long_lat_eff;
  end

  assign pend[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : g_pend
    hazard_pend_entry #(.LW(LW)) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tracked && sb.dec_rd == AW'(r)),
      .load_val (load_val),
      .pend     (pend[r])
    );
  end

  assign raw = sb.dec_valid &&
               ((sb.dec_rs1_use && sb.dec_rs1 != '0 && pend[sb.dec_rs1] != '0) ||
                (sb.dec_rs2_use && sb.dec_rs2 != '0 && pend[sb.dec_rs2] != '0));
  assign waw        = sb.dec_valid && sb.dec_we && sb.dec_rd != '0 && pend[sb.dec_rd] != '0;
  assign struct_haz = sb.dec_valid && is_long && long_cnt != '0;
  assign hazard     = raw || waw || struct_haz;
  assign stall      = hazard && !sb.pc_change_ex;
  assign issue      = sb.dec_valid && !stall && !sb.pc_change_ex;
  assign tracked    = issue && sb.dec_we && sb.dec_rd != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                long_cnt <= '0;
    else if (issue && is_long) long_cnt <= long_lat_eff;
    else if (long_cnt != '0)   long_cnt <= long_cnt - LW'(1);
  end

  // LONG results retire straight into the regfile, so they never enter the bypass shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
    end else begin
      ex_s  <= '{valid: tracked && !is_long, rd: SLOT_AW'(sb.dec_rd)};
      mem_s <= ex_s;
      wb_s  <= mem_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign sb.fwd_sel_rs1 = fwd_pick(SLOT_AW'(sb.dec_rs1), ex_s, mem_s, wb_s);
  assign sb.fwd_sel_rs2 = fwd_pick(SLOT_AW'(sb.dec_rs2), ex_s, mem_s, wb_s);
  assign sb.stall_if    = stall;
  assign sb.stall_dec   = stall;
  assign sb.flush_dec   = sb.pc_change_ex;
  assign sb.flush_ex    = sb.pc_change_ex || stall;
  assign sb.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected control words queued at drive time, checked at negedge.
module tb_hazard_scoreboard;

  localparam logic [1:0] ALU  = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] LONG = 2'b10;
  localparam logic [1:0] RSVD = 2'b11;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic [1:0] cls;
    logic [3:0] lat;
    logic       pc;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  hazard_scoreboard_if #(.AW(5), .LW(4)) bus ();

  hazard_scoreboard #(.NREG(32), .LW(4), .LOAD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic we, input logic [1:0] cls, input logic [3:0] lat,
                              input logic pc);
    ins_t i;
    i = '{v: v, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, we: we, cls: cls, lat: lat, pc: pc};
    return i;
  endfunction

  // {stall_if, stall_dec, flush_dec, flush_ex, fwd_sel_rs1, fwd_sel_rs2}
  function automatic logic [31:0] ctl(input logic st, input logic pc,
                                      input logic [1:0] f1, input logic [1:0] f2);
    return {24'd0, st, st, pc, pc | st, f1, f2};
  endfunction

  function automatic logic [31:0] obs_ctl();
    return {24'd0, bus.stall_if, bus.stall_dec, bus.flush_dec, bus.flush_ex,
            bus.fwd_sel_rs1, bus.fwd_sel_rs2};
  endfunction

  task automatic drive(input ins_t i);
    bus.dec_valid    = i.v;
    bus.dec_rs1      = i.rs1;
    bus.dec_rs1_use  = i.u1;
    bus.dec_rs2      = i.rs2;
    bus.dec_rs2_use  = i.u2;
    bus.dec_rd       = i.rd;
    bus.dec_we       = i.we;
    bus.dec_cls      = i.cls;
    bus.dec_long_lat = i.lat;
    bus.pc_change_ex = i.pc;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    tag = tag_q.pop_front();
    e   = exp_q.pop_front();
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Drive just after a rising edge, compare at the falling edge, then clock it in.
  task automatic step(input string tag, input ins_t i, input logic [31:0] e);
    drive(i);
    expect_val(tag, e);
    @(negedge clk);
    check(obs_ctl());
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] e);
    expect_val(tag, e);
    check(bus.stall_cnt);
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 0));
    @(posedge clk);
    #1;
    // Held in reset: outputs depend only on pc_change_ex.
    step("rst_out",    mk(1, 5, 1, 7, 1, 5, 1, LOAD, 0, 0), ctl(0, 0, 0, 0));
    step("rst_out_pc", mk(1, 5, 1, 7, 1, 5, 1, LOAD, 0, 1), ctl(0, 1, 0, 0));
    check_cnt("rst_cnt", 32'd0);
    rst_n = 1'b1;

    // ALU producer bypassed from EX, MEM, then WB.
    step("alu_rd5",  mk(1, 0, 0, 0, 0, 5, 1, ALU, 0, 0), ctl(0, 0, 0, 0));
    step("fwd_ex",   mk(1, 5, 1, 0, 0, 0, 0, ALU, 0, 0), ctl(0, 0, 1, 0));
    step("fwd_mem",  mk(1, 5, 1, 0, 0, 0, 0, ALU, 0, 0), ctl(0, 0, 2, 0));
    step("fwd_wb",   mk(1, 5, 1, 0, 0, 0, 0, ALU, 0, 0), ctl(0, 0, 3, 0));
    step("pc_only",  mk(0, 0, 0, 0, 0, 0, 0, ALU, 0, 1), ctl(0, 1, 0, 0));

    // Load-use: one bubble, then MEM bypass.
    step("ld_rd7",    mk(1, 0, 0, 0, 0, 7, 1, LOAD, 0, 0), ctl(0, 0, 0, 0));
    step("ld_use",    mk(1, 0, 0, 7, 1, 0, 0, ALU, 0, 0),  ctl(1, 0, 0, 1));
    step("ld_use_go", mk(1, 0, 0, 7, 1, 0, 0, ALU, 0, 0),  ctl(0, 0, 0, 2));

    // Load-use coinciding with a redirect: flush wins, nothing issues.
    step("ld_rd8",      mk(1, 0, 0, 0, 0, 8, 1, LOAD, 0, 0), ctl(0, 0, 0, 0));
    step("ld_use_pc",   mk(1, 8, 1, 0, 0, 3, 1, ALU, 0, 1),  ctl(0, 1, 1, 0));
    step("no_pend_upd", mk(1, 3, 1, 8, 1, 0, 0, ALU, 0, 0),  ctl(0, 0, 0, 2));

    // x0 is never a hazard or a bypass source.
    step("ld_x0",   mk(1, 0, 0, 0, 0, 0, 1, LOAD, 0, 0), ctl(0, 0, 0, 0));
    step("x0_read", mk(1, 0, 1, 0, 1, 0, 0, ALU, 0, 0),  ctl(0, 0, 0, 0));

    // LONG latency 4: reader stalls four cycles, no bypass.
    step("long_rd9", mk(1, 0, 0, 0, 0, 9, 1, LONG, 4, 0), ctl(0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      step("long_raw", mk(1, 9, 1, 0, 0, 0, 0, ALU, 0, 0), ctl(1, 0, 0, 0));
    step("long_raw_go", mk(1, 9, 1, 0, 0, 0, 0, ALU, 0, 0), ctl(0, 0, 0, 0));
    check_cnt("cnt5", 32'd5);

    // Structural: second LONG waits for the unit; latency 0 behaves as 1.
    step("long_rd10", mk(1, 0, 0, 0, 0, 10, 1, LONG, 2, 0), ctl(0, 0, 0, 0));
    for (int k = 0; k < 2; k++)
      step("struct", mk(1, 0, 0, 0, 0, 11, 1, LONG, 0, 0), ctl(1, 0, 0, 0));
    step("struct_go", mk(1, 0, 0, 0, 0, 11, 1, LONG, 0, 0), ctl(0, 0, 0, 0));
    step("lat0_raw",  mk(1, 0, 0, 11, 1, 0, 0, ALU, 0, 0),  ctl(1, 0, 0, 0));
    step("lat0_go",   mk(1, 0, 0, 11, 1, 0, 0, ALU, 0, 0),  ctl(0, 0, 0, 0));

    // WAW on a pending load destination.
    step("ld_rd12", mk(1, 0, 0, 0, 0, 12, 1, LOAD, 0, 0), ctl(0, 0, 0, 0));
    step("waw",     mk(1, 0, 0, 0, 0, 12, 1, ALU, 0, 0),  ctl(1, 0, 0, 0));
    step("waw_go",  mk(1, 0, 0, 0, 0, 12, 1, ALU, 0, 0),  ctl(0, 0, 0, 0));
    check_cnt("cnt9", 32'd9);

    // Reserved class behaves as ALU; both sources bypassed at once.
    step("rsvd_rd13", mk(1, 0, 0, 0, 0, 13, 1, RSVD, 0, 0), ctl(0, 0, 0, 0));
    step("rsvd_fwd",  mk(1, 13, 1, 12, 1, 0, 0, ALU, 0, 0), ctl(0, 0, 1, 2));

    // Asynchronous reset in the middle of a LONG stall.
    step("long_rd9b", mk(1, 0, 0, 0, 0, 9, 1, LONG, 4, 0), ctl(0, 0, 0, 0));
    step("mid_stall", mk(1, 9, 1, 0, 0, 0, 0, ALU, 0, 0),  ctl(1, 0, 0, 0));
    expect_val("mid_stall2", ctl(1, 0, 0, 0));
    @(negedge clk);
    check(obs_ctl());
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("rst_async", ctl(0, 0, 0, 0));
    check(obs_ctl());
    check_cnt("rst_async_cnt", 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_go",    mk(1, 9, 1, 0, 0, 0, 0, ALU, 0, 0),   ctl(0, 0, 0, 0));
    step("post_rst_long",  mk(1, 0, 0, 0, 0, 14, 1, LONG, 3, 0), ctl(0, 0, 0, 0));
    step("post_rst_long2", mk(1, 0, 0, 0, 0, 15, 1, LONG, 3, 0), ctl(1, 0, 0, 0));
    check_cnt("cnt1", 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, 32, number of architectural registers.
REQ-002 Parameter AW, $clog2(NREG), register-index width.
REQ-003 Parameter LW, 4, latency-counter width.
REQ-004 Parameter LOAD_LAT, 1, cycles a load destination stays unavailable after issue (range 1..2^LW-1).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 dec_valid  in  1  decode holds a valid instruction.
REQ-008 dec_rs1, dec_rs2  in  AW  source indices; dec_rs1_use, dec_rs2_use  in  1  source actually read.
REQ-009 dec_rd  in  AW  destination; dec_we  in  1  instruction writes rd.
REQ-010 dec_cls  in  2  class: 00 ALU, 01 LOAD, 10 LONG (mul/div), 11 reserved, treated as ALU.
REQ-011 dec_long_lat  in  LW  completion latency of a LONG op.
REQ-012 pc_change_ex  in  1  taken branch or jump resolved in EX.
REQ-013 fwd_sel_rs1, fwd_sel_rs2  out  2  bypass select: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-014 stall_if, stall_dec, flush_dec, flush_ex  out  1  pipeline control.
REQ-015 stall_cnt  out  32  count of stalled cycles.

Function
REQ-016 issue = dec_valid & ~stall_dec & ~pc_change_ex; tracked = issue & dec_we & (dec_rd != 0).
REQ-017 Per-register counter pend[r] (LW bits); on tracked, pend[dec_rd] loads 0 (ALU), LOAD_LAT (LOAD), or max(dec_long_lat,1) (LONG).
REQ-018 Every other nonzero pend[r] decrements by 1 per cycle; a same-cycle load on the same entry wins over the decrement; pend[0] is constant 0.
REQ-019 raw = dec_valid & ((dec_rs1_use & dec_rs1!=0 & pend[dec_rs1]!=0) | (dec_rs2_use & dec_rs2!=0 & pend[dec_rs2]!=0)).
REQ-020 waw = dec_valid & dec_we & dec_rd!=0 & pend[dec_rd]!=0.
REQ-021 Counter long_cnt (LW bits) loads max(dec_long_lat,1) on issue of a LONG op and decrements to 0; struct = dec_valid & dec_cls==LONG & long_cnt!=0.
REQ-022 hazard = raw | waw | struct; stall_if = stall_dec = hazard & ~pc_change_ex (combinational, same cycle).
REQ-023 flush_dec = pc_change_ex; flush_ex = pc_change_ex | (hazard & ~pc_change_ex), inserting a bubble.
REQ-024 Shadow pipeline of three slots EX->MEM->WB, each {valid, rd}; per clock EX <= {tracked & dec_cls!=LONG, dec_rd}, MEM <= EX, WB <= MEM.
REQ-025 fwd_sel_rsN = youngest valid slot whose rd equals dec_rsN (EX over MEM over WB); 00 when dec_rsN==0 or no match.
REQ-026 LONG results write the regfile at completion and are never bypassed; the regfile is write-before-read.
REQ-027 stall_cnt increments on each cycle with stall_dec=1 and saturates at 32'hFFFF_FFFF.
REQ-028 Simultaneous pc_change_ex and hazard: no stall, no issue, decode flushed.
REQ-029 Back-to-back issues to one rd: the WAW stall holds the younger instruction until pend clears.

Reset
REQ-030 While rst_n=0: every pend[r]=0, long_cnt=0, all shadow slots invalid, stall_cnt=0.
REQ-031 After reset, outputs are purely a function of the current inputs: fwd_sel=00, and stall/flush follow pc_change_ex only.
REQ-032 Reset asserted mid-stall or mid-LONG clears all state within the same cycle (asynchronous).

Structure
REQ-033 Package hazard_pkg holds the dec_cls and fwd_sel encodings, the shadow-slot struct, and the NREG/LW defaults.
REQ-034 Sub-module hazard_pend_entry is a single per-register load/decrement counter, instantiated NREG-1 times.

Verification
REQ-035 ALU rd=5 issued, then next instruction reads rs1=5 -> no stall, fwd_sel_rs1=01; one cycle later fwd_sel_rs1=10.
REQ-036 LOAD rd=7 (LOAD_LAT=1), then instruction reads rs2=7 -> exactly 1 stall cycle with flush_ex=1; next cycle fwd_sel_rs2=10.
REQ-037 LONG rd=9 with lat=4, then a reader of rs1=9 -> 4 stall cycles; a second LONG issued meanwhile stalls until long_cnt=0.
REQ-038 Load-use hazard with pc_change_ex=1 in the same cycle -> stall_if=0, flush_dec=1, flush_ex=1, no pend update.
REQ-039 rd=0 LOAD followed by a reader of x0 -> no stall, fwd_sel=00.
REQ-040 rst_n pulsed low during the LONG stall of REQ-037 -> stall drops immediately and stall_cnt reads 0.
